// File: rtl/pool_relu_pkg.sv
// Shared types and constants for the pool_relu block: FSM states, lane geometry and a
// lane-wise ReLU helper used when the optional ReLU stage is built in.
package pool_relu_pkg;

    localparam int LANES  = 4;
    localparam int LANE_W = 8;
    localparam int WORD_W = LANES * LANE_W;

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        RD1,
        RD2,
        RD3,
        WR,
        DONE
    } state_t;

    // Clamp every negative signed lane to zero.
    function automatic logic [WORD_W-1:0] relu_word(input logic [WORD_W-1:0] w);
        logic [WORD_W-1:0] o;
        o = '0;
        for (int k = 0; k < LANES; k++) begin
            o[k*LANE_W +: LANE_W] = w[k*LANE_W + LANE_W - 1] ? '0 : w[k*LANE_W +: LANE_W];
        end
        return o;
    endfunction

endpackage

// File: rtl/pool_lane_max.sv
// Combinational lane-wise signed maximum of two packed words of int8 lanes.
module pool_lane_max
    import pool_relu_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic [WORD_W-1:0] y
);

    always_comb begin
        y = '0;
        for (int k = 0; k < LANES; k++) begin
            if ($signed(a[k*LANE_W +: LANE_W]) > $signed(b[k*LANE_W +: LANE_W]))
                y[k*LANE_W +: LANE_W] = a[k*LANE_W +: LANE_W];
            else
                y[k*LANE_W +: LANE_W] = b[k*LANE_W +: LANE_W];
        end
    end

endmodule

// File: rtl/pool_relu.sv
// 2x2 stride-2 max-pool over packed int8 feature maps, one output word every 5 cycles.
// Define POOL_RELU_EN to clamp each pooled lane at zero (ReLU after pool).
module pool_relu
    import pool_relu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        fm_w,
    input  logic [7:0]        fm_h,
    input  logic [7:0]        n_grp,
    output logic [31:0]       src_addr,
    input  logic [WORD_W-1:0] src_rdata,
    output logic [31:0]       dst_addr,
    output logic [3:0]        dst_wreq,
    output logic [WORD_W-1:0] dst_wdata,
    output logic              busy,
    output logic              done
);

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        w_q;
    logic [7:0]        h_q;
    logic [7:0]        n_q;
    logic [7:0]        grp;
    logic [7:0]        row;
    logic [7:0]        col;
    logic [7:0]        rd_row;
    logic [7:0]        rd_col;
    logic [31:0]       src_idx;
    logic [31:0]       out_idx;
    logic [WORD_W-1:0] max_q;
    logic [WORD_W-1:0] max_new;
    logic [WORD_W-1:0] pooled;
    logic              degenerate;
    logic              last_col;
    logic              last_row;
    logic              last_grp;

    assign degenerate = (fm_w < 8'd2) || (fm_h < 8'd2) || (n_grp == 8'd0);
    // A further window exists only if a full 2-wide/2-high pair still fits.
    assign last_col   = ({1'b0, col} + 9'd4) > {1'b0, w_q};
    assign last_row   = ({1'b0, row} + 9'd4) > {1'b0, h_q};
    assign last_grp   = ({1'b0, grp} + 9'd1) >= {1'b0, n_q};

    assign busy = (state != IDLE) && (state != DONE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = degenerate ? DONE : RD0;
            RD0:     state_nxt = RD1;
            RD1:     state_nxt = RD2;
            RD2:     state_nxt = RD3;
            RD3:     state_nxt = WR;
            WR:      state_nxt = (last_col && last_row && last_grp) ? DONE : RD0;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_row = row;
        rd_col = col;
        case (state)
            RD1: rd_col = col + 8'd1;
            RD2: rd_row = row + 8'd1;
            RD3: begin
                rd_row = row + 8'd1;
                rd_col = col + 8'd1;
            end
            default: ;
        endcase
    end

    assign src_idx  = ({24'd0, grp} * {24'd0, h_q} + {24'd0, rd_row}) * {24'd0, w_q}
                    + {24'd0, rd_col};
    assign src_addr = (state == RD0 || state == RD1 || state == RD2 || state == RD3)
                    ? (src_idx << 2) : 32'd0;

    pool_lane_max u_lane_max (
        .a (max_q),
        .b (src_rdata),
        .y (max_new)
    );

`ifdef POOL_RELU_EN
    assign pooled = relu_word(max_new);
`else
    assign pooled = max_new;
`endif

    // Read data lags the address by one cycle, so RD1 sees the first word and WR the fourth.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_q       <= '0;
            h_q       <= '0;
            n_q       <= '0;
            grp       <= '0;
            row       <= '0;
            col       <= '0;
            out_idx   <= '0;
            max_q     <= '0;
            dst_addr  <= '0;
            dst_wdata <= '0;
            dst_wreq  <= '0;
        end else begin
            dst_wreq <= 4'h0;
            case (state)
                IDLE: begin
                    if (start) begin
                        w_q     <= fm_w;
                        h_q     <= fm_h;
                        n_q     <= n_grp;
                        grp     <= '0;
                        row     <= '0;
                        col     <= '0;
                        out_idx <= '0;
                    end
                end
                RD1:     max_q <= src_rdata;
                RD2,
                RD3:     max_q <= max_new;
                WR: begin
                    dst_wreq  <= 4'hF;
                    dst_wdata <= pooled;
                    dst_addr  <= out_idx << 2;
                    out_idx   <= out_idx + 32'd1;
                    if (!last_col) begin
                        col <= col + 8'd2;
                    end else begin
                        col <= '0;
                        if (!last_row) begin
                            row <= row + 8'd2;
                        end else begin
                            row <= '0;
                            grp <= grp + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pool_relu.sv
// Scoreboard bench for pool_relu: a BRAM model feeds src_rdata, a reference pool model
// pushes expected writes, and each scenario task compares observed writes against them.
module tb_pool_relu;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  fm_w;
    logic [7:0]  fm_h;
    logic [7:0]  n_grp;
    logic [31:0] src_addr;
    logic [31:0] src_rdata;
    logic [31:0] dst_addr;
    logic [3:0]  dst_wreq;
    logic [31:0] dst_wdata;
    logic        busy;
    logic        done;

    logic [31:0] src_mem [0:1023];
    bit          touched [0:1023];
    wr_t         exp_q[$];
    wr_t         obs_q[$];

    int          n_checks;
    int          n_errors;
    int          done_cycle;
    bit          timed_out;
    bit          src_active;
    bit          wreq_bad;
    logic        busy_at0;
    logic        busy_at_done;
    logic [31:0] addr_at1;

    pool_relu dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .fm_w      (fm_w),
        .fm_h      (fm_h),
        .n_grp     (n_grp),
        .src_addr  (src_addr),
        .src_rdata (src_rdata),
        .dst_addr  (dst_addr),
        .dst_wreq  (dst_wreq),
        .dst_wdata (dst_wdata),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) src_rdata <= src_mem[src_addr[11:2]];

    // Reference model: walk every complete 2x2 window and push the expected write.
    task automatic model_push(input int w, input int h, input int n);
        int          oidx;
        logic [31:0] wd [4];
        logic [31:0] res;
        logic signed [7:0] m;
        logic signed [7:0] v;
        oidx = 0;
        for (int g = 0; g < n; g++)
            for (int r = 0; r + 1 < h; r += 2)
                for (int c = 0; c + 1 < w; c += 2) begin
                    wd[0] = src_mem[(g*h + r)*w + c];
                    wd[1] = src_mem[(g*h + r)*w + c + 1];
                    wd[2] = src_mem[(g*h + r + 1)*w + c];
                    wd[3] = src_mem[(g*h + r + 1)*w + c + 1];
                    res = '0;
                    for (int k = 0; k < 4; k++) begin
                        m = wd[0][k*8 +: 8];
                        for (int j = 1; j < 4; j++) begin
                            v = wd[j][k*8 +: 8];
                            if (v > m) m = v;
                        end
`ifdef POOL_RELU_EN
                        if (m < 0) m = 0;
`endif
                        res[k*8 +: 8] = m;
                    end
                    exp_q.push_back('{addr: 32'(oidx*4), data: res});
                    oidx++;
                end
    endtask

    task automatic pulse_start(input int w, input int h, input int n);
        @(negedge clk);
        fm_w  = 8'(w);
        fm_h  = 8'(h);
        n_grp = 8'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Observe one pass sample by sample on falling edges; cycle 0 is the cycle after acceptance.
    task automatic run_pass(input int max_cycles, input int inject_start_at, input int reset_at);
        obs_q.delete();
        timed_out    = 1'b1;
        done_cycle   = -1;
        src_active   = 1'b0;
        wreq_bad     = 1'b0;
        busy_at0     = 1'b0;
        busy_at_done = 1'b1;
        addr_at1     = 'x;
        for (int i = 0; i < 1024; i++) touched[i] = 1'b0;
        for (int cyc = 0; cyc < max_cycles; cyc++) begin
            if (cyc == reset_at) begin
                rst       = 1'b0;
                timed_out = 1'b0;
                return;
            end
            if (dst_wreq !== 4'h0) begin
                obs_q.push_back('{addr: dst_addr, data: dst_wdata});
                if (dst_wreq !== 4'hF) wreq_bad = 1'b1;
            end
            touched[src_addr[11:2]] = 1'b1;
            if (src_addr !== 32'd0) src_active = 1'b1;
            if (cyc == 0) busy_at0 = busy;
            if (cyc == 1) addr_at1 = src_addr;
            if (done === 1'b1) begin
                done_cycle   = cyc;
                busy_at_done = busy;
                timed_out    = 1'b0;
                break;
            end
            if (cyc == inject_start_at) begin
                fm_w  = 8'd2;
                fm_h  = 8'd2;
                n_grp = 8'd1;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({src_addr, dst_addr, dst_wdata, dst_wreq, busy, done} !== '0) begin
            n_errors++;
            $display("[TB] FAIL reset_outputs: got src=%h dst=%h wd=%h wreq=%h busy=%b done=%b, expected all 0",
                     src_addr, dst_addr, dst_wdata, dst_wreq, busy, done);
        end
        rst = 1'b1;
        run_pass(4, -1, -1);
        n_checks++;
        if (obs_q.size() != 0 || busy !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL reset_idle: got %0d writes busy=%b, expected 0 writes busy=0",
                     obs_q.size(), busy);
        end
    endtask

    task automatic test_basic_4x4(input int inject_start_at);
        for (int p = 0; p < 16; p++) begin
            logic [7:0] b;
            b = 8'(p);
            src_mem[p] = {4{b}};
        end
        model_push(4, 4, 1);
        pulse_start(4, 4, 1);
        run_pass(100, inject_start_at, -1);
        n_checks++;
        if (timed_out || done_cycle != 20) begin
            n_errors++;
            $display("[TB] FAIL basic_done_latency: got cycle %0d (timeout=%b), expected 20",
                     done_cycle, timed_out);
        end
        n_checks++;
        if (busy_at0 !== 1'b1 || busy_at_done !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL basic_busy: got start=%b at_done=%b, expected 1 and 0",
                     busy_at0, busy_at_done);
        end
        n_checks++;
        if (addr_at1 !== 32'd4) begin
            n_errors++;
            $display("[TB] FAIL basic_rd1_addr: got %h, expected 00000004", addr_at1);
        end
        n_checks++;
        if (obs_q.size() != exp_q.size() || wreq_bad) begin
            n_errors++;
            $display("[TB] FAIL basic_write_count: got %0d (bad wreq=%b), expected %0d",
                     obs_q.size(), wreq_bad, exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            wr_t e;
            wr_t o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_errors++;
                $display("[TB] FAIL basic_write: got addr %h data %h, expected addr %h data %h",
                         o.addr, o.data, e.addr, e.data);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_mixed_lanes();
        logic [31:0] want;
`ifdef POOL_RELU_EN
        want = 32'h7F000304;
`else
        want = 32'h7FFF0304;
`endif
        src_mem[0] = 32'h80FF0102;
        src_mem[1] = 32'h81FE0203;
        src_mem[2] = 32'h7FFD0001;
        src_mem[3] = 32'h00FC0304;
        model_push(2, 2, 1);
        pulse_start(2, 2, 1);
        run_pass(50, -1, -1);
        n_checks++;
        if (obs_q.size() != 1 || timed_out) begin
            n_errors++;
            $display("[TB] FAIL mixed_count: got %0d writes (timeout=%b), expected 1",
                     obs_q.size(), timed_out);
        end else begin
            wr_t e;
            wr_t o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e || o.data !== want) begin
                n_errors++;
                $display("[TB] FAIL mixed_write: got addr %h data %h, expected addr %h data %h",
                         o.addr, o.data, e.addr, want);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_odd_dims();
        int bad;
        for (int i = 0; i < 30; i++) src_mem[i] = $urandom;
        model_push(5, 3, 2);
        pulse_start(5, 3, 2);
        run_pass(100, -1, -1);
        n_checks++;
        if (obs_q.size() != 4 || timed_out) begin
            n_errors++;
            $display("[TB] FAIL odd_count: got %0d writes (timeout=%b), expected 4",
                     obs_q.size(), timed_out);
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            wr_t e;
            wr_t o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_errors++;
                $display("[TB] FAIL odd_write: got addr %h data %h, expected addr %h data %h",
                         o.addr, o.data, e.addr, e.data);
            end
        end
        exp_q.delete();
        bad = 0;
        for (int g = 0; g < 2; g++) begin
            for (int c = 0; c < 5; c++) if (touched[(g*3 + 2)*5 + c]) bad++;
            for (int r = 0; r < 2; r++) if (touched[(g*3 + r)*5 + 4]) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("[TB] FAIL odd_dropped_reads: got %0d reads of row 2 / column 4, expected 0", bad);
        end
    endtask

    task automatic test_degenerate();
        int cfg [3][3];
        cfg = '{'{1, 4, 1}, '{4, 1, 1}, '{4, 4, 0}};
        for (int t = 0; t < 3; t++) begin
            pulse_start(cfg[t][0], cfg[t][1], cfg[t][2]);
            run_pass(20, -1, -1);
            n_checks++;
            if (timed_out || done_cycle != 0 || obs_q.size() != 0 || src_active) begin
                n_errors++;
                $display("[TB] FAIL degenerate_%0d: got done cycle %0d writes %0d reads %b, expected 0/0/0",
                         t, done_cycle, obs_q.size(), src_active);
            end
        end
    endtask

    task automatic test_reset_midpass();
        int seen;
        pulse_start(4, 4, 1);
        run_pass(100, -1, 7);
        #1;
        n_checks++;
        if ({src_addr, dst_addr, dst_wdata, dst_wreq, busy, done} !== '0) begin
            n_errors++;
            $display("[TB] FAIL midpass_reset: got src=%h dst=%h wd=%h wreq=%h busy=%b done=%b, expected all 0",
                     src_addr, dst_addr, dst_wdata, dst_wreq, busy, done);
        end
        repeat (2) @(negedge clk);
        rst  = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (dst_wreq !== 4'h0 || busy !== 1'b0) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_errors++;
            $display("[TB] FAIL post_reset_quiet: got %0d active cycles, expected 0", seen);
        end
        test_basic_4x4(-1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 72; i++) src_mem[i] = $urandom;
        model_push(6, 4, 3);
        pulse_start(6, 4, 3);
        fm_w  = 8'd9;
        fm_h  = 8'd7;
        n_grp = 8'd1;
        run_pass(300, -1, -1);
        n_checks++;
        if (timed_out || done_cycle != 90 || obs_q.size() != exp_q.size()) begin
            n_errors++;
            $display("[TB] FAIL b2b_first: got done cycle %0d writes %0d, expected 90 and %0d",
                     done_cycle, obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            wr_t e;
            wr_t o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_errors++;
                $display("[TB] FAIL b2b_write: got addr %h data %h, expected addr %h data %h",
                         o.addr, o.data, e.addr, e.data);
            end
        end
        exp_q.delete();
        model_push(4, 2, 2);
        pulse_start(4, 2, 2);
        run_pass(100, -1, -1);
        n_checks++;
        if (timed_out || done_cycle != 20 || obs_q.size() != exp_q.size()) begin
            n_errors++;
            $display("[TB] FAIL b2b_second: got done cycle %0d writes %0d, expected 20 and %0d",
                     done_cycle, obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            wr_t e;
            wr_t o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_errors++;
                $display("[TB] FAIL b2b_write2: got addr %h data %h, expected addr %h data %h",
                         o.addr, o.data, e.addr, e.data);
            end
        end
        exp_q.delete();
    endtask

    initial begin
        clk      = 1'b0;
        rst      = 1'b0;
        start    = 1'b0;
        fm_w     = '0;
        fm_h     = '0;
        n_grp    = '0;
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 1024; i++) src_mem[i] = '0;
        test_reset();
        test_basic_4x4(-1);
        test_mixed_lanes();
        test_odd_dims();
        test_degenerate();
        $display("[TB] start while busy");
        test_basic_4x4(3);
        test_reset_midpass();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
